dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 12 +
 rtl/dmem_arbiter.sv | 41 ++++
 tb/tb_dmem_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's access port into the shared data memory arbiter.
interface dmem_arbiter_if #(parameter int DEPTH = 10);
    logic             req;
    logic             we;
    logic [DEPTH-1:0] addr;
    logic [31:0]      wdata;
    logic             gnt;
    logic             rvalid;
    logic [31:0]      rdata;
    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the CPU and the debug unit, CPU first with a starvation guard for debug.
module dmem_arbiter #(
    parameter int DEPTH    = 10,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     cpu,
    dmem_arbiter_if.slave     dbg,
    output logic [DEPTH-1:0]  mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);
    logic [3:0] wait_cnt;
    logic       dbg_pri;
    // Debug overrides the CPU once it has been denied MAX_WAIT cycles in a row.
    assign dbg_pri = dbg.req && wait_cnt == 4'(MAX_WAIT);
    assign cpu.gnt = !rst && cpu.req && !dbg_pri;
    assign dbg.gnt = !rst && dbg.req && (dbg_pri || !cpu.req);
    always_comb begin
        mem_addr  = cpu.gnt ? cpu.addr  : dbg.gnt ? dbg.addr  : '0;
        mem_wdata = cpu.gnt ? cpu.wdata : dbg.gnt ? dbg.wdata : '0;
        mem_we    = cpu.gnt ? cpu.we    : dbg.gnt && dbg.we;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt   <= '0;
            cpu.rvalid <= 1'b0;
            dbg.rvalid <= 1'b0;
            cpu.rdata  <= '0;
            dbg.rdata  <= '0;
        end else begin
            wait_cnt   <= (dbg.req && !dbg.gnt) ? (dbg_pri ? wait_cnt : wait_cnt + 4'd1) : 4'd0;
            cpu.rvalid <= cpu.gnt;
            dbg.rvalid <= dbg.gnt;
            if (cpu.gnt) cpu.rdata <= mem_rdata;
            if (dbg.gnt) dbg.rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a queue scoreboard; a negedge monitor checks every rvalid/rdata.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic [31:0] mem [1024];
    logic [31:0] cpu_q [$];
    logic [31:0] dbg_q [$];
    logic [31:0] cpu_last = '0;
    logic [31:0] dbg_last = '0;
    int errors = 0;
    int checks = 0;

    dmem_arbiter_if #(.DEPTH(10)) cpu_if ();
    dmem_arbiter_if #(.DEPTH(10)) dbg_if ();

    dmem_arbiter #(.DEPTH(10), .MAX_WAIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu       (cpu_if),
        .dbg       (dbg_if),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write committed on the rising edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [9:0] ca, input logic [31:0] cd,
                         input logic dr, input logic dw, input logic [9:0] da, input logic [31:0] dd);
        cpu_if.req = cr; cpu_if.we = cw; cpu_if.addr = ca; cpu_if.wdata = cd;
        dbg_if.req = dr; dbg_if.we = dw; dbg_if.addr = da; dbg_if.wdata = dd;
    endtask

    task automatic step(input logic cr, input logic cw, input logic [9:0] ca, input logic [31:0] cd,
                        input logic dr, input logic dw, input logic [9:0] da, input logic [31:0] dd,
                        input logic ecg, input logic edg, input logic [31:0] ecr, input logic [31:0] edr,
                        input string nm);
        drive(cr, cw, ca, cd, dr, dw, da, dd);
        @(negedge clk);
        chk({nm, " cpu_gnt"}, 32'(cpu_if.gnt), 32'(ecg));
        chk({nm, " dbg_gnt"}, 32'(dbg_if.gnt), 32'(edg));
        chk({nm, " mem_addr"}, 32'(mem_addr), ecg ? 32'(ca) : edg ? 32'(da) : 32'd0);
        chk({nm, " mem_we"}, 32'(mem_we), ecg ? 32'(cw) : edg ? 32'(dw) : 32'd0);
        chk({nm, " mem_wdata"}, mem_wdata, ecg ? cd : edg ? dd : 32'd0);
        if (ecg) cpu_q.push_back(ecr);
        if (edg) dbg_q.push_back(edr);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst cpu_rvalid", 32'(cpu_if.rvalid), 32'd0);
            chk("rst cpu_rdata", cpu_if.rdata, 32'd0);
            chk("rst dbg_rvalid", 32'(dbg_if.rvalid), 32'd0);
            chk("rst dbg_rdata", dbg_if.rdata, 32'd0);
            cpu_last = '0;
            dbg_last = '0;
        end else begin
            if (cpu_if.rvalid) begin
                if (cpu_q.size() == 0) chk("cpu unexpected rvalid", 32'd1, 32'd0);
                else chk("cpu rdata", cpu_if.rdata, cpu_q.pop_front());
                cpu_last = cpu_if.rdata;
            end else chk("cpu rdata hold", cpu_if.rdata, cpu_last);
            if (dbg_if.rvalid) begin
                if (dbg_q.size() == 0) chk("dbg unexpected rvalid", 32'd1, 32'd0);
                else chk("dbg rdata", dbg_if.rdata, dbg_q.pop_front());
                dbg_last = dbg_if.rdata;
            end else chk("dbg rdata hold", dbg_if.rdata, dbg_last);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[10'h005] = 32'hDEADBEEF;
        mem[10'h010] = 32'h11111111;
        mem[10'h011] = 32'h22222222;
        mem[10'h3FF] = 32'hCAFEF00D;
        // Requests held during reset must not be granted nor write memory.
        drive(1, 1, 10'h005, 32'hBAD0BAD0, 1, 1, 10'h3FF, 32'hBAD1BAD1);
        #1;
        chk("rst cpu_gnt", 32'(cpu_if.gnt), 32'd0);
        chk("rst dbg_gnt", 32'(dbg_if.gnt), 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
        step(1, 0, 10'h005, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 0, "cpu read");
        for (int i = 0; i < 10; i++)
            step(1, 0, 10'h010, 0, 1, 0, 10'h011, 0, i % 5 != 4, i % 5 == 4, 32'h11111111, 32'h22222222, "starve");
        step(0, 0, 0, 0, 1, 1, 10'h3FF, 32'h12345678, 0, 1, 0, 32'hCAFEF00D, "dbg write");
        step(1, 0, 10'h3FF, 0, 0, 0, 0, 0, 1, 0, 32'h12345678, 0, "cpu raw");
        for (int i = 0; i < 2; i++)
            step(1, 0, 10'h005, 0, 1, 0, 10'h010, 0, 1, 0, 32'hDEADBEEF, 0, "dbg pulse");
        for (int i = 0; i < 3; i++)
            step(1, 0, 10'h005, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 0, "dbg dropped");
        for (int i = 0; i < 5; i++)
            step(1, 0, 10'h005, 0, 1, 0, 10'h010, 0, i != 4, i == 4, 32'hDEADBEEF, 32'h11111111, "wait cleared");
        step(1, 1, 10'h020, 32'hA5A5A5A5, 0, 0, 0, 0, 1, 0, 32'h0, 0, "cpu write");
        step(1, 0, 10'h020, 0, 0, 0, 0, 0, 1, 0, 32'hA5A5A5A5, 0, "cpu b2b read");
        step(1, 1, 10'h030, 32'h55555555, 0, 0, 0, 0, 1, 0, 32'h0, 0, "pre-reset write");
        // Asynchronous reset in the response cycle kills the pending rvalid.
        #1;
        rst = 1'b1;
        cpu_q.delete();
        drive(1, 1, 10'h031, 32'h66666666, 1, 1, 10'h032, 32'h77777777);
        #1;
        chk("async cpu_rvalid", 32'(cpu_if.rvalid), 32'd0);
        chk("async cpu_rdata", cpu_if.rdata, 32'd0);
        chk("async cpu_gnt", 32'(cpu_if.gnt), 32'd0);
        chk("async mem_we", 32'(mem_we), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("no write in reset", mem[10'h031], 32'd0);
        rst = 1'b0;
        step(1, 0, 10'h030, 0, 1, 0, 10'h3FF, 0, 1, 0, 32'h55555555, 0, "post-reset read");
        step(1, 0, 10'h031, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0, "post-reset blocked");
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle end");
        chk("cpu queue drained", 32'(cpu_q.size()), 32'd0);
        chk("dbg queue drained", 32'(dbg_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
